// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback queue.
// Entry layout and producer port indices.
package wb_pkg;

  localparam int WB_SIZE    = 32;
  localparam int WB_REG_NUM = 8;
  localparam int WB_RW      = $clog2(WB_REG_NUM);

  localparam logic ALU_PORT  = 1'b0;
  localparam logic LOAD_PORT = 1'b1;

  typedef struct packed {
    logic [WB_RW-1:0]   rd;
    logic [WB_SIZE-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of pending writebacks.
// Exposes every slot plus a valid mask for hazard compares.
module wb_fifo
  import wb_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  i_rst_n,
  input  logic                  i_push,
  input  wb_entry_t             i_entry,
  input  logic                  i_pop,
  output wb_entry_t             o_head,
  output wb_entry_t [DEPTH-1:0] o_mem,
  output logic [DEPTH-1:0]      o_valid,
  output logic [CW-1:0]         o_count
);

  wb_entry_t [DEPTH-1:0] r_mem;
  logic [AW-1:0]         r_head;
  logic [AW-1:0]         r_tail;
  logic [CW-1:0]         r_count;
  logic [AW-1:0]         w_off [DEPTH];

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_tail] <= i_entry;
        r_tail        <= r_tail + 1'b1;
      end
      if (i_pop) begin
        r_head <= r_head + 1'b1;
      end
      unique case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // A slot is live when its distance from head is below occupancy.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      w_off[k]   = AW'(k) - r_head;
      o_valid[k] = CW'(w_off[k]) < r_count;
    end
  end

  assign o_head  = r_mem[r_head];
  assign o_mem   = r_mem;
  assign o_count = r_count;

endmodule

// File: rtl/wb_queue.sv
// Round-robin writeback queue feeding one register-file write port.
// Also flags pending writes per decode read port.
module wb_queue
  import wb_pkg::*;
#(
  parameter  int SIZE       = WB_SIZE,
  parameter  int REG_NUM    = WB_REG_NUM,
  parameter  int DEPTH      = 4,
  parameter  int READ_PORTS = 2,
  localparam int RW         = $clog2(REG_NUM),
  localparam int CW         = $clog2(DEPTH + 1)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [1:0]                     in_valid,
  output logic [1:0]                     in_ready,
  input  logic [1:0][RW-1:0]             in_reg,
  input  logic [1:0][SIZE-1:0]           in_data,
  input  logic                           wb_stall,
  output logic                           RegWrite,
  output logic [RW-1:0]                  write_reg,
  output logic [SIZE-1:0]                write_data,
  input  logic [READ_PORTS-1:0][RW-1:0]  query_reg,
  output logic [READ_PORTS-1:0]          query_pending,
  output logic [CW-1:0]                  count
);

  logic                  r_rr;
  logic                  r_we;
  logic [RW-1:0]         r_wreg;
  logic [SIZE-1:0]       r_wdata;

  logic                  w_gvld;
  logic                  w_gsel;
  logic                  w_space;
  logic                  w_push;
  logic                  w_pop;
  wb_entry_t             w_entry;
  wb_entry_t             w_head;
  wb_entry_t [DEPTH-1:0] w_mem;
  logic [DEPTH-1:0]      w_valid;
  logic [CW-1:0]         w_count;

  always_comb begin
    w_gvld = 1'b1;
    w_gsel = r_rr;
    unique case (in_valid)
      2'b01:   w_gsel = ALU_PORT;
      2'b10:   w_gsel = LOAD_PORT;
      2'b11:   w_gsel = r_rr;
      default: w_gvld = 1'b0;
    endcase
  end

  // When full, a push is still legal if a pop frees a slot on the same edge.
  assign w_space = (w_count != CW'(DEPTH)) || !wb_stall;

  always_comb begin
    in_ready = '0;
    if (rst_n && w_gvld && w_space) begin
      in_ready[w_gsel] = 1'b1;
    end
  end

  assign w_push       = |in_ready;
  assign w_pop        = rst_n && (w_count != '0) && !wb_stall;
  assign w_entry.rd   = in_reg[w_gsel];
  assign w_entry.data = in_data[w_gsel];

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .i_rst_n (rst_n),
    .i_push  (w_push),
    .i_entry (w_entry),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_mem   (w_mem),
    .o_valid (w_valid),
    .o_count (w_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rr <= 1'b0;
    end else if (w_push) begin
      r_rr <= ~w_gsel;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_wreg  <= '0;
      r_wdata <= '0;
    end else if (w_pop) begin
      r_we    <= 1'b1;
      r_wreg  <= w_head.rd;
      r_wdata <= w_head.data;
    end else begin
      r_we    <= 1'b0;
    end
  end

  // Stored state only: same-cycle producers are not visible here.
  always_comb begin
    query_pending = '0;
    for (int j = 0; j < READ_PORTS; j++) begin
      if (r_we && (r_wreg == query_reg[j])) begin
        query_pending[j] = 1'b1;
      end
      for (int k = 0; k < DEPTH; k++) begin
        if (w_valid[k] && (w_mem[k].rd == query_reg[j])) begin
          query_pending[j] = 1'b1;
        end
      end
    end
  end

  assign RegWrite   = r_we;
  assign write_reg  = r_wreg;
  assign write_data = r_wdata;
  assign count      = w_count;

endmodule

// File: tb/tb_wb_queue.sv
// Self-checking bench for wb_queue.
// Directed scenarios then random traffic against a queue model.
module tb_wb_queue;

  localparam int DEPTH = 4;

  logic             clk;
  logic             rst_n;
  logic [1:0]       in_valid;
  logic [1:0]       in_ready;
  logic [1:0][2:0]  in_reg;
  logic [1:0][31:0] in_data;
  logic             wb_stall;
  logic             RegWrite;
  logic [2:0]       write_reg;
  logic [31:0]      write_data;
  logic [1:0][2:0]  query_reg;
  logic [1:0]       query_pending;
  logic [2:0]       count;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [2:0]  rd;
    logic [31:0] d;
  } ment_t;

  ment_t       mq[$];
  logic        m_rr;
  logic        m_we;
  logic [2:0]  m_wreg;
  logic [31:0] m_wdata;

  wb_queue #(
    .SIZE       (32),
    .REG_NUM    (8),
    .DEPTH      (DEPTH),
    .READ_PORTS (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_reg        (in_reg),
    .in_data       (in_data),
    .wb_stall      (wb_stall),
    .RegWrite      (RegWrite),
    .write_reg     (write_reg),
    .write_data    (write_data),
    .query_reg     (query_reg),
    .query_pending (query_pending),
    .count         (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_rr    = 1'b0;
    m_we    = 1'b0;
    m_wreg  = '0;
    m_wdata = '0;
  endtask

  task automatic step(input logic [1:0] v, input logic [2:0] r0,
                      input logic [2:0] r1, input logic [31:0] d0,
                      input logic [31:0] d1, input logic st,
                      input logic [2:0] q0, input logic [2:0] q1,
                      input logic rn);
    logic       sel;
    logic [1:0] er;
    logic [1:0] ep;
    logic [2:0] qr [2];
    ment_t      e;
    @(negedge clk);
    in_valid     = v;
    in_reg[0]    = r0;
    in_reg[1]    = r1;
    in_data[0]   = d0;
    in_data[1]   = d1;
    wb_stall     = st;
    query_reg[0] = q0;
    query_reg[1] = q1;
    rst_n        = rn;
    #1;
    sel = (v == 2'b11) ? m_rr : v[1];
    er  = 2'b00;
    if (rn && v != 2'b00 && (mq.size() < DEPTH || !st)) begin
      er = sel ? 2'b10 : 2'b01;
    end
    qr[0] = q0;
    qr[1] = q1;
    for (int j = 0; j < 2; j++) begin
      ep[j] = m_we && (m_wreg == qr[j]);
      foreach (mq[k]) if (mq[k].rd == qr[j]) ep[j] = 1'b1;
    end
    chk("in_ready", 64'(in_ready), 64'(er));
    chk("count", 64'(count), 64'(mq.size()));
    chk("RegWrite", 64'(RegWrite), 64'(m_we));
    chk("write_reg", 64'(write_reg), 64'(m_wreg));
    chk("write_data", 64'(write_data), 64'(m_wdata));
    chk("query_pending", 64'(query_pending), 64'(ep));
    @(posedge clk);
    if (!rn) begin
      model_reset();
    end else begin
      if (mq.size() > 0 && !st) begin
        e       = mq.pop_front();
        m_we    = 1'b1;
        m_wreg  = e.rd;
        m_wdata = e.d;
      end else begin
        m_we = 1'b0;
      end
      if (er != 2'b00) begin
        e.rd = sel ? r1 : r0;
        e.d  = sel ? d1 : d0;
        mq.push_back(e);
        m_rr = ~sel;
      end
    end
  endtask

  task automatic idle(input int n, input logic [2:0] q0,
                      input logic [2:0] q1);
    for (int i = 0; i < n; i++) begin
      step(2'b00, 3'd0, 3'd0, 32'd0, 32'd0, 1'b0, q0, q1, 1'b1);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = '0;
    in_reg    = '0;
    in_data   = '0;
    wb_stall  = 1'b0;
    query_reg = '0;
    model_reset();
    @(posedge clk);

    // single push, two-edge latency
    step(2'b01, 3'd3, 3'd0, 32'hDEADBEEF, 32'd0, 1'b0, 3'd3, 3'd4, 1'b1);
    idle(4, 3'd3, 3'd4);

    // both ports every cycle: alternating grant
    for (int i = 0; i < 6; i++) begin
      step(2'b11, 3'(i), 3'(i + 1), 32'(100 + i), 32'(200 + i), 1'b0,
           3'(i), 3'(i + 1), 1'b1);
    end
    idle(3, 3'd1, 3'd2);

    // stall until full, then push+pop while full
    for (int i = 0; i < 4; i++) begin
      step(2'b01, 3'(i + 4), 3'd0, 32'(300 + i), 32'd0, 1'b1,
           3'(i + 4), 3'd1, 1'b1);
    end
    step(2'b11, 3'd1, 3'd2, 32'd7, 32'd8, 1'b1, 3'd4, 3'd7, 1'b1);
    step(2'b10, 3'd0, 3'd2, 32'd0, 32'h55, 1'b0, 3'd5, 3'd2, 1'b1);
    idle(6, 3'd2, 3'd6);

    // same destination twice: later data wins
    step(2'b01, 3'd5, 3'd0, 32'd1, 32'd0, 1'b0, 3'd5, 3'd6, 1'b1);
    step(2'b01, 3'd5, 3'd0, 32'd2, 32'd0, 1'b0, 3'd5, 3'd6, 1'b1);
    idle(4, 3'd5, 3'd6);

    // reset mid-drain discards everything
    for (int i = 0; i < 4; i++) begin
      step(2'b10, 3'd0, 3'(i + 1), 32'd0, 32'(400 + i), 1'b1,
           3'd1, 3'd2, 1'b1);
    end
    step(2'b00, 3'd0, 3'd0, 32'd0, 32'd0, 1'b0, 3'd1, 3'd2, 1'b1);
    step(2'b11, 3'd1, 3'd2, 32'd9, 32'd9, 1'b0, 3'd2, 3'd3, 1'b0);
    idle(4, 3'd2, 3'd3);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(2'($urandom_range(0, 3)), 3'($urandom), 3'($urandom),
           $urandom, $urandom, ($urandom_range(0, 9) < 3),
           3'($urandom), 3'($urandom), ($urandom_range(0, 59) != 0));
    end
    idle(8, 3'd0, 3'd7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_queue.md
# wb_queue

Writeback queue that collects completed results from two producers (ALU and load unit) and serialises them onto the single write port of the register file. Accepts at most one result per cycle using a round-robin valid/ready handshake, buffers up to DEPTH results, and drives one registered write per cycle. Also reports, per register-file read port, whether a queued write to the queried register is still pending, for hazard stalling in decode.

## Interface
- SIZE, 32, data width (matches register file)
- REG_NUM, 8, number of architectural registers; index width RW = $clog2(REG_NUM)
- DEPTH, 4, FIFO entries (power of two, ≥2)
- READ_PORTS, 2, number of pending-query ports

- clk  in  1  clock, all state updates on posedge
- rst_n  in  1  synchronous active-low reset, sampled on posedge clk
- in_valid  in  [1:0]  producer i has a result
- in_ready  out  [1:0]  producer i's result is accepted this cycle
- in_reg  in  [1:0][RW-1:0]  destination register per producer
- in_data  in  [1:0][SIZE-1:0]  result data per producer
- wb_stall  in  1  hold: no pop into the write port this cycle
- RegWrite  out  1  registered write enable to register file
- write_reg  out  RW  registered write index
- write_data  out  SIZE  registered write data
- query_reg  in  [READ_PORTS-1:0][RW-1:0]  registers being read by decode
- query_pending  out  [READ_PORTS-1:0]  a write to query_reg[j] is queued or on the write port
- count  out  $clog2(DEPTH+1)  current FIFO occupancy

## Operation
- Grant (combinational): one valid → that port; both valid → port rr; none → no grant.
- in_ready[i] = rst_n && grant==i && (count<DEPTH || !wb_stall); never both high.
- Push: in_valid[i] && in_ready[i] → {in_reg[i], in_data[i]} written at tail, tail++ mod DEPTH; rr ← 1-i. rr unchanged when no push.
- Pop: count>0 && !wb_stall → head entry loaded into write_reg/write_data, RegWrite←1, head++ mod DEPTH. Otherwise (empty or stall) RegWrite←0; write_reg/write_data hold their previous values.
- Push and pop in one cycle: count unchanged; permitted when full only if not stalled (space freed same edge).
- Order: entries written to the register file strictly in acceptance order; two queued writes to the same register both issue, the later wins.
- query_pending[j] (combinational on stored state only) = OR over valid FIFO entries of (reg==query_reg[j]) OR (RegWrite && write_reg==query_reg[j]). Same-cycle input is not included.
- Register index 0 is not special; writes to it issue normally.
- Reset (rst_n low at posedge): head=tail=0, count=0, rr=0, RegWrite=0, write_reg=0, write_data=0; all queued entries discarded, including mid-drain. in_ready low while rst_n low.

## Timing
- Result accepted at edge N → earliest RegWrite high during cycle after edge N+1 → register file captures it at the following negedge (write_* stable across that negedge since updated on posedge only).
- Accept-to-write latency: 2 posedges minimum, plus one per stalled cycle and per older entry.
- Throughput: one accept and one write per cycle sustained.
- in_ready depends combinationally on in_valid and wb_stall; no combinational path from in_data/in_reg to any output other than none (query_pending depends only on query_reg and state).
- count reflects state after the last edge; pops for the current write port entry are not counted.

## Structure
- Package wb_pkg: parameterised struct typedef wb_entry_t {reg, data} via localparam widths, port-index constants ALU_PORT=0, LOAD_PORT=1.
- One sub-module wb_fifo: storage array, head/tail/count, push/pop, per-entry valid vector exposed for the pending compare. Arbitration, output register and query logic live in wb_queue.

## Test plan
- Reset then single push port 0 reg=3 data=0xDEADBEEF → RegWrite high exactly one cycle, two posedges after accept, write_reg=3, write_data=0xDEADBEEF; count back to 0.
- Both ports valid every cycle for 6 cycles after reset → accepts alternate 0,1,0,1,0,1; writes appear in that order, one per cycle.
- wb_stall high, push 4 entries → count=4, in_ready both low with valid high; query_pending high for each queued reg; deassert stall → 4 writes on consecutive cycles, in order.
- Full and not stalled, port 1 valid → push and pop same edge, count stays 4, no entry lost.
- Queue regs 5 then 5 (data 1, 2) → two writes, second data=2; query_pending[0] for reg 5 high until after the second write's RegWrite cycle, low for reg 6 throughout.
- rst_n low for one cycle with 3 entries queued and RegWrite high → next cycle RegWrite=0, write_reg=0, write_data=0, count=0, query_pending all 0, no further writes.
